// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the instruction memory it drives.
package fetch_unit_pkg;

    // Default PC / instruction-memory address width (word addressed).
    localparam int unsigned ADDR_WIDTH_DEFAULT = 10;

    // Instruction word as stored in instr_mem.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [13:0] imm;
    } instruction_s;

    typedef enum logic {
        HALT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory, holds its output under stall, takes redirects from execute and
// forwards program-load writes into memory while halted.
//
// state | meaning
// ------+--------------------------------------------------------------
// HALT  | no fetching; load port forwarded to memory; waits for start_i
// FETCH | sequential fetch, one instruction per cycle to decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned addr_width_p = ADDR_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    n_reset_i,
    input  logic                    start_i,
    input  logic [addr_width_p-1:0] start_pc_i,
    input  logic                    halt_i,
    input  logic                    stall_i,
    input  logic                    redirect_v_i,
    input  logic [addr_width_p-1:0] redirect_pc_i,
    input  logic                    load_v_i,
    input  logic [addr_width_p-1:0] load_addr_i,
    input  instruction_s            load_instr_i,
    output logic [addr_width_p-1:0] imem_addr_o,
    output logic                    imem_wen_o,
    output instruction_s            imem_instr_o,
    input  instruction_s            imem_instr_i,
    output logic                    instr_v_o,
    output instruction_s            instr_o,
    output logic [addr_width_p-1:0] pc_o
);

    localparam logic [addr_width_p-1:0] PC_ONE = {{(addr_width_p-1){1'b0}}, 1'b1};

    fetch_state_e            state_q;
    logic [addr_width_p-1:0] fetch_pc_q;
    logic                    pend_v_q;
    logic [addr_width_p-1:0] pend_pc_q;
    logic                    hold_v_q;
    instruction_s            hold_instr_q;
    logic                    fetch_active;

    // Output side is a pure function of the registers so an async reset
    // takes effect on the outputs immediately; the memory word in flight
    // is masked by instr_v_o.
    always_comb begin
        fetch_active = (state_q == FETCH);
        instr_v_o    = fetch_active & pend_v_q;
        instr_o      = '0;
        if (instr_v_o) begin
            instr_o = hold_v_q ? hold_instr_q : imem_instr_i;
        end
        pc_o         = pend_pc_q;
        imem_wen_o   = ~fetch_active & load_v_i;
        imem_addr_o  = imem_wen_o ? load_addr_i : fetch_pc_q;
        imem_instr_o = load_instr_i;
    end

    // State and PC/hold datapath. Priority in FETCH: halt > redirect >
    // stall > advance. During a stall the memory keeps reading the next
    // PC, so on release its output is already the following instruction.
    always_ff @(posedge clk or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q      <= HALT;
            fetch_pc_q   <= '0;
            pend_v_q     <= 1'b0;
            pend_pc_q    <= '0;
            hold_v_q     <= 1'b0;
            hold_instr_q <= '0;
        end else if (state_q == HALT) begin
            if (start_i) begin
                state_q    <= FETCH;
                fetch_pc_q <= start_pc_i;
            end
        end else begin
            if (halt_i) begin
                state_q  <= HALT;
                pend_v_q <= 1'b0;
                hold_v_q <= 1'b0;
            end else if (redirect_v_i) begin
                fetch_pc_q <= redirect_pc_i;
                pend_v_q   <= 1'b0;
                hold_v_q   <= 1'b0;
            end else if (stall_i && instr_v_o) begin
                hold_instr_q <= instr_o;
                hold_v_q     <= 1'b1;
            end else begin
                pend_pc_q  <= fetch_pc_q;
                pend_v_q   <= 1'b1;
                fetch_pc_q <= fetch_pc_q + PC_ONE;
                hold_v_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a behavioural synchronous instruction memory.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start, halt, stall, redir, load_v;
    logic [AW-1:0] start_pc, redir_pc, load_addr;
    instruction_s  load_instr;
    logic [AW-1:0] imem_addr;
    logic          imem_wen;
    instruction_s  imem_wdata, imem_rdata;
    logic          instr_v;
    instruction_s  instr;
    logic [AW-1:0] pc;

    instruction_s  mem  [DEPTH];
    instruction_s  gold [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Synchronous memory: read data one cycle after the address.
    always @(posedge clk) begin
        if (imem_wen) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr];
    end

    fetch_unit #(.addr_width_p(AW)) dut (
        .clk           (clk),
        .n_reset_i     (n_reset),
        .start_i       (start),
        .start_pc_i    (start_pc),
        .halt_i        (halt),
        .stall_i       (stall),
        .redirect_v_i  (redir),
        .redirect_pc_i (redir_pc),
        .load_v_i      (load_v),
        .load_addr_i   (load_addr),
        .load_instr_i  (load_instr),
        .imem_addr_o   (imem_addr),
        .imem_wen_o    (imem_wen),
        .imem_instr_o  (imem_wdata),
        .imem_instr_i  (imem_rdata),
        .instr_v_o     (instr_v),
        .instr_o       (instr),
        .pc_o          (pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    // Returns in the cycle right after the start edge (expected bubble).
    task automatic do_start(input logic [AW-1:0] spc);
        start    = 1'b1;
        start_pc = spc;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        start = 0; halt = 0; stall = 0; redir = 0; load_v = 0;
        start_pc = '0; redir_pc = '0; load_addr = '0; load_instr = '0;
        #12;
        n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_v); end
        n_cmp++; if (instr !== '0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (pc !== '0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_cmp++; if (imem_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", imem_wen); end
        n_cmp++; if (imem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        @(posedge clk); #1;
        n_reset = 1'b1;
        tick();
    endtask

    // Fill the whole memory through the load port while halted.
    task automatic test_load_all();
        for (int i = 0; i < DEPTH; i++) begin
            load_v     = 1'b1;
            load_addr  = AW'(i);
            load_instr = instruction_s'($urandom);
            gold[i]    = load_instr;
            #1;
            n_cmp++; if (imem_wen !== 1'b1 || imem_addr !== AW'(i)) begin
                n_err++; $display("FAIL load_port: got wen=%b addr=%h want wen=1 addr=%h", imem_wen, imem_addr, AW'(i));
            end
            tick();
        end
        load_v = 1'b0;
    endtask

    task automatic test_load_start();
        go_halt();
        for (int i = 0; i < 4; i++) begin
            load_v     = 1'b1;
            load_addr  = AW'(i);
            load_instr = instruction_s'($urandom);
            gold[i]    = load_instr;
            if (i == 3) begin
                start    = 1'b1;
                start_pc = '0;
            end
            tick();
        end
        load_v = 1'b0;
        start  = 1'b0;
        n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL start_bubble: got %b want 0", instr_v); end
        n_cmp++; if (imem_wen !== 1'b0) begin n_err++; $display("FAIL fetch_wen: got %b want 0", imem_wen); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(k) || instr !== gold[k]) begin
                n_err++; $display("FAIL start_seq: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", instr_v, pc, instr, AW'(k), gold[k]);
            end
        end
    endtask

    task automatic test_stall();
        go_halt();
        do_start('0);
        tick(); tick(); tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(2) || instr !== gold[2]) begin
                n_err++; $display("FAIL stall_hold: got v=%b pc=%h i=%h want v=1 pc=002 i=%h", instr_v, pc, instr, gold[2]);
            end
            tick();
        end
        stall = 1'b0;
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(2) || instr !== gold[2]) begin
            n_err++; $display("FAIL stall_release: got v=%b pc=%h i=%h want v=1 pc=002 i=%h", instr_v, pc, instr, gold[2]);
        end
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(3) || instr !== gold[3]) begin
            n_err++; $display("FAIL stall_next: got v=%b pc=%h i=%h want v=1 pc=003 i=%h", instr_v, pc, instr, gold[3]);
        end
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(4) || instr !== gold[4]) begin
            n_err++; $display("FAIL stall_next2: got v=%b pc=%h i=%h want v=1 pc=004 i=%h", instr_v, pc, instr, gold[4]);
        end
    endtask

    task automatic test_redirect();
        go_halt();
        do_start(AW'(5));
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(5)) begin
            n_err++; $display("FAIL redir_pre: got v=%b pc=%h want v=1 pc=005", instr_v, pc);
        end
        redir    = 1'b1;
        redir_pc = AW'(12'h100);
        tick();
        redir = 1'b0;
        n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %b want 0", instr_v); end
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(12'h100) || instr !== gold[12'h100]) begin
            n_err++; $display("FAIL redir_target: got v=%b pc=%h i=%h want v=1 pc=100 i=%h", instr_v, pc, instr, gold[12'h100]);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e;
        go_halt();
        do_start(AW'(12'h3FE));
        e = AW'(12'h3FE);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (instr_v !== 1'b1 || pc !== e || instr !== gold[e]) begin
                n_err++; $display("FAIL wrap: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", instr_v, pc, instr, e, gold[e]);
            end
            e = e + AW'(1);
        end
    endtask

    task automatic test_redirect_stall_halt();
        instruction_s w;
        go_halt();
        do_start(AW'(10));
        tick();
        stall = 1'b1;
        tick();
        redir    = 1'b1;
        redir_pc = AW'(12'h2A0);
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(10) || instr !== gold[10]) begin
            n_err++; $display("FAIL rs_held: got v=%b pc=%h i=%h want v=1 pc=00a i=%h", instr_v, pc, instr, gold[10]);
        end
        tick();
        redir = 1'b0;
        n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL rs_bubble: got %b want 0", instr_v); end
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(12'h2A0) || instr !== gold[12'h2A0]) begin
            n_err++; $display("FAIL rs_target: got v=%b pc=%h i=%h want v=1 pc=2a0 i=%h", instr_v, pc, instr, gold[12'h2A0]);
        end
        stall = 1'b0;
        halt  = 1'b1;
        tick();
        halt = 1'b0;
        n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL halt_valid: got %b want 0", instr_v); end
        w          = instruction_s'($urandom);
        load_v     = 1'b1;
        load_addr  = AW'(7);
        load_instr = w;
        #1;
        n_cmp++; if (imem_wen !== 1'b1 || imem_addr !== AW'(7)) begin
            n_err++; $display("FAIL halt_load: got wen=%b addr=%h want wen=1 addr=007", imem_wen, imem_addr);
        end
        gold[7] = w;
        tick();
        load_v = 1'b0;
        do_start(AW'(7));
        tick();
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(7) || instr !== gold[7]) begin
            n_err++; $display("FAIL halt_reload: got v=%b pc=%h i=%h want v=1 pc=007 i=%h", instr_v, pc, instr, gold[7]);
        end
    endtask

    task automatic test_async_reset();
        go_halt();
        do_start(AW'(20));
        tick(); tick();
        load_v     = 1'b1;
        load_addr  = AW'(3);
        load_instr = instruction_s'($urandom);
        #1;
        n_cmp++; if (imem_wen !== 1'b0) begin n_err++; $display("FAIL fetch_load_wen: got %b want 0", imem_wen); end
        n_cmp++; if (instr_v !== 1'b1 || pc !== AW'(21)) begin
            n_err++; $display("FAIL ar_pre: got v=%b pc=%h want v=1 pc=015", instr_v, pc);
        end
        load_v = 1'b0;
        #1;
        n_reset = 1'b0;
        #1;
        n_cmp++; if (instr_v !== 1'b0 || instr !== '0 || pc !== '0) begin
            n_err++; $display("FAIL ar_out: got v=%b pc=%h i=%h want v=0 pc=0 i=0", instr_v, pc, instr);
        end
        n_cmp++; if (imem_wen !== 1'b0 || imem_addr !== '0) begin
            n_err++; $display("FAIL ar_mem: got wen=%b addr=%h want wen=0 addr=0", imem_wen, imem_addr);
        end
        @(posedge clk); #1;
        n_reset = 1'b1;
        tick();
    endtask

    // Transaction-level model: after a start/redirect to T there is exactly
    // one bubble, then PCs T, T+1, ... each advancing only when accepted.
    task automatic test_random();
        logic [AW-1:0] exp_pc;
        int            gap;
        bit            vis;
        go_halt();
        exp_pc = AW'($urandom);
        do_start(exp_pc);
        gap = 1;
        for (int c = 0; c < 400; c++) begin
            stall      = ($urandom_range(0, 9) < 3);
            redir      = ($urandom_range(0, 19) == 0);
            redir_pc   = AW'($urandom);
            load_v     = ($urandom_range(0, 3) == 0);
            load_addr  = AW'($urandom);
            load_instr = instruction_s'($urandom);
            #1;
            n_cmp++; if (imem_wen !== 1'b0) begin n_err++; $display("FAIL rand_wen: got %b want 0", imem_wen); end
            vis = (gap == 0);
            if (!vis) begin
                gap--;
                n_cmp++; if (instr_v !== 1'b0) begin n_err++; $display("FAIL rand_bubble: got %b want 0", instr_v); end
            end else begin
                n_cmp++; if (instr_v !== 1'b1 || pc !== exp_pc || instr !== gold[exp_pc]) begin
                    n_err++; $display("FAIL rand_stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", instr_v, pc, instr, exp_pc, gold[exp_pc]);
                end
            end
            if (redir) begin
                exp_pc = redir_pc;
                gap    = 1;
            end else if (vis && !stall) begin
                exp_pc = exp_pc + AW'(1);
            end
            tick();
        end
        stall = 0; redir = 0; load_v = 0;
    endtask

    initial begin
        test_reset();
        test_load_all();
        test_load_start();
        test_stall();
        test_redirect();
        test_wrap();
        test_redirect_stall_halt();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
